// File: rtl/pkg_include.sv
// ============================================================================
// Module : pkg_include
// Brief  : Shared types and helpers for the systolic array controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pkg_include;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } sa_ctrl_state_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_ctrl.sv
// ============================================================================
// Module : systolic_ctrl
// Brief  : Sequencer for one systolic tile pass: clear, feed, drain, flush, done.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_ctrl
  import pkg_include::*;
#(
  parameter int TILE_DIM = 64,
  parameter int K_MAX    = 256
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [$clog2(K_MAX)-1:0]     rd_addr,
  output logic                         arr_clr,
  output logic                         arr_enb,
  output logic                         zero_inj
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int AW = $clog2(K_MAX);
  // One counter serves both FEED and DRAIN, so it must span the longer phase.
  localparam int CW = $clog2(max2(K_MAX, 2 * TILE_DIM - 1) + 1);

  localparam logic [KW-1:0] c_K_MAX      = KW'(K_MAX);
  localparam logic [CW-1:0] c_DRAIN_LAST = CW'(2 * TILE_DIM - 2);

  sa_ctrl_state_t r_state;
  sa_ctrl_state_t w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [KW-1:0]  r_klen;
  logic [CW-1:0]  w_feed_last;
  logic           r_arr_enb;
  logic           r_zero_inj;
  logic           w_accept;

  assign w_accept    = (r_state == ST_IDLE) && start && !abort;
  assign w_feed_last = CW'(r_klen) - CW'(1);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_klen  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_klen <= (k_len > c_K_MAX) ? c_K_MAX : k_len;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = (r_klen != '0) ? ST_FEED : ST_DRAIN;
      end
      ST_FEED: begin
        if (r_cnt == w_feed_last) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (r_cnt == c_DRAIN_LAST) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_FLUSH: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end
  end

  // Delayed by one cycle to line up with the operand buffer read latency.
  always_ff @(posedge clk) begin
    if (!rstn || abort) begin
      r_arr_enb  <= 1'b0;
      r_zero_inj <= 1'b0;
    end else begin
      r_arr_enb  <= (r_state == ST_FEED) || (r_state == ST_DRAIN);
      r_zero_inj <= (r_state == ST_DRAIN);
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE) && !abort;
  assign rd_en    = (r_state == ST_FEED);
  assign rd_addr  = (r_state == ST_FEED) ? r_cnt[AW-1:0] : '0;
  assign arr_clr  = (r_state == ST_CLEAR);
  assign arr_enb  = r_arr_enb;
  assign zero_inj = r_zero_inj;

endmodule

`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
// ============================================================================
// Module : tb_systolic_ctrl
// Brief  : Directed self-checking bench for systolic_ctrl (TILE_DIM=4, K_MAX=8).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_ctrl;

  localparam int TILE_DIM = 4;
  localparam int K_MAX    = 8;
  localparam int KW       = $clog2(K_MAX + 1);
  localparam int AW       = $clog2(K_MAX);

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          arr_clr;
  logic          arr_enb;
  logic          zero_inj;

  int n_err = 0;
  int n_chk = 0;
  int addr_q[$];

  systolic_ctrl #(.TILE_DIM(TILE_DIM), .K_MAX(K_MAX)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .k_len(k_len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .arr_clr(arr_clr), .arr_enb(arr_enb), .zero_inj(zero_inj)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_rd_en"},    rd_en,    0);
    chk({tag, "_rd_addr"},  rd_addr,  0);
    chk({tag, "_arr_clr"},  arr_clr,  0);
    chk({tag, "_arr_enb"},  arr_enb,  0);
    chk({tag, "_zero_inj"}, zero_inj, 0);
  endtask

  // Timeline model: c counts cycles after the start-accept edge.
  task automatic chk_cycle(input int c, input int ke);
    chk("busy",     busy,     1);
    chk("arr_clr",  arr_clr,  c == 1);
    chk("rd_en",    rd_en,    (c >= 2) && (c <= ke + 1));
    chk("arr_enb",  arr_enb,  (c >= 3) && (c <= ke + 2*TILE_DIM + 1));
    chk("zero_inj", zero_inj, (c >= ke + 3) && (c <= ke + 2*TILE_DIM + 1));
    chk("done",     done,     c == ke + 2*TILE_DIM + 2);
    if (rd_en) begin
      chk("addr_q_avail", addr_q.size() > 0, 1);
      if (addr_q.size() > 0) chk("rd_addr", rd_addr, addr_q.pop_front());
    end else begin
      chk("rd_addr_idle", rd_addr, 0);
    end
  endtask

  // Entered at the negedge of the cycle in which start is presented.
  task automatic run_op(input int k, input bit hold, input int abort_at, input int rst_at);
    int ke;
    int last;
    ke   = (k > K_MAX) ? K_MAX : k;
    last = ke + 2*TILE_DIM + 2;
    addr_q.delete();
    for (int a = 0; a < ke; a++) addr_q.push_back(a);
    start = 1'b1;
    k_len = KW'(k);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      chk_cycle(c, ke);
      if (c == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_quiet("after_abort");
        addr_q.delete();
        return;
      end
      if (c == rst_at) begin
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk_quiet("after_reset");
        addr_q.delete();
        return;
      end
    end
    chk("addr_q_drained", addr_q.size(), 0);
  endtask

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    k_len = '0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    run_op(4, 1'b0, -1, -1);
    @(negedge clk);
    chk_quiet("idle_after_k4");

    run_op(0, 1'b0, -1, -1);
    @(negedge clk);
    chk_quiet("idle_after_k0");

    // Abort while rd_addr==2 (cycle 4 of the timeline).
    run_op(4, 1'b0, 4, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet("post_abort_idle");
    end
    run_op(1, 1'b0, -1, -1);
    @(negedge clk);

    // Start and abort together in IDLE must be ignored.
    start = 1'b1;
    abort = 1'b1;
    k_len = KW'(3);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_quiet("start_abort_idle");
    @(negedge clk);
    chk_quiet("start_abort_idle2");

    // Start held high: exactly one IDLE cycle between done and the next CLEAR.
    run_op(4, 1'b1, -1, -1);
    @(negedge clk);
    chk("b2b_gap_busy", busy, 0);
    chk("b2b_gap_clr", arr_clr, 0);
    run_op(2, 1'b0, -1, -1);
    @(negedge clk);

    run_op(K_MAX + 5, 1'b0, -1, -1);
    @(negedge clk);

    // Reset asserted in DRAIN (cycles 6..12 for k=4).
    run_op(4, 1'b0, -1, 8);
    @(negedge clk);
    chk_quiet("post_reset_idle");

    run_op(K_MAX, 1'b0, -1, -1);
    @(negedge clk);
    chk_quiet("final_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
